// File: rtl/m_cycle_cpu.sv
// Multi-cycle MIPS-subset core: one instruction walks FETCH/DECODE/EXEC/MEM/WB.
// A single memory port serves both fetches and data accesses with a req/ready handshake.
module m_cycle_cpu #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halt,
    output logic [31:0] pc_out
);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_SLT,
        OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI,
        OP_LW, OP_SW, OP_BEQ, OP_J, OP_ILL
    } op_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        halt_q, halt_d;

    logic [31:0] rf_q [0:31];
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] imm_s, imm_z;
    logic [31:0] rs_val, rt_val;
    logic [31:0] alu_y, ea;
    logic [31:0] br_tgt, jmp_tgt;
    logic        is_alu;
    op_t         op;

    assign opc   = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign shamt = ir_q[10:6];
    assign fn    = ir_q[5:0];
    assign imm   = ir_q[15:0];
    assign imm_s = {{16{imm[15]}}, imm};
    assign imm_z = {16'h0000, imm};

    assign rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];

    assign ea      = a_q + imm_s;
    assign br_tgt  = pc_q + {imm_s[29:0], 2'b00};
    assign jmp_tgt = {pc_q[31:28], ir_q[25:0], 2'b00};

    always_comb begin
        op = OP_ILL;
        case (opc)
            6'h00: begin
                if (shamt == 5'd0) begin
                    case (fn)
                        6'h21:   op = OP_ADDU;
                        6'h23:   op = OP_SUBU;
                        6'h24:   op = OP_AND;
                        6'h25:   op = OP_OR;
                        6'h2A:   op = OP_SLT;
                        default: op = OP_ILL;
                    endcase
                end
            end
            6'h09:   op = OP_ADDIU;
            6'h0C:   op = OP_ANDI;
            6'h0D:   op = OP_ORI;
            6'h0F:   op = OP_LUI;
            6'h23:   op = OP_LW;
            6'h2B:   op = OP_SW;
            6'h04:   op = OP_BEQ;
            6'h02:   op = OP_J;
            default: op = OP_ILL;
        endcase
    end

    always_comb begin
        alu_y = 32'd0;
        case (op)
            OP_ADDU:  alu_y = a_q + b_q;
            OP_SUBU:  alu_y = a_q - b_q;
            OP_AND:   alu_y = a_q & b_q;
            OP_OR:    alu_y = a_q | b_q;
            OP_SLT:   alu_y = {31'd0, ($signed(a_q) < $signed(b_q))};
            OP_ADDIU: alu_y = a_q + imm_s;
            OP_ANDI:  alu_y = a_q & imm_z;
            OP_ORI:   alu_y = a_q | imm_z;
            OP_LUI:   alu_y = {imm, 16'h0000};
            default:  alu_y = 32'd0;
        endcase
    end

    assign is_alu = (op == OP_ADDU) || (op == OP_SUBU) || (op == OP_AND) ||
                    (op == OP_OR)   || (op == OP_SLT)  || (op == OP_ADDIU) ||
                    (op == OP_ANDI) || (op == OP_ORI)  || (op == OP_LUI);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        halt_d   = halt_q;
        rf_we    = 1'b0;
        rf_waddr = (opc == 6'h00) ? rd : rt;
        rf_wdata = (op == OP_LW) ? mdr_q : alu_q;

        case (state_q)
            FETCH: begin
                // req_q is only low here on the first cycle after reset
                if (!req_q) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_q;
                end else if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    req_d   = 1'b0;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d = rs_val;
                b_d = rt_val;
                if (op != OP_ILL) begin
                    state_d = EXEC;
                end else if (HALT_ON_ILLEGAL) begin
                    state_d = HALT;
                    halt_d  = 1'b1;
                end else begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = pc_q;
                    wdata_d = 32'd0;
                end
            end
            EXEC: begin
                if (is_alu) begin
                    alu_d   = alu_y;
                    state_d = WB;
                end else if (op == OP_LW || op == OP_SW) begin
                    alu_d = ea;
                    if (ea[1:0] != 2'b00) begin
                        state_d = HALT;
                        halt_d  = 1'b1;
                    end else begin
                        state_d = MEM;
                        req_d   = 1'b1;
                        we_d    = (op == OP_SW);
                        addr_d  = ea;
                        wdata_d = (op == OP_SW) ? b_q : 32'd0;
                    end
                end else begin
                    if (op == OP_BEQ && a_q == b_q) begin
                        pc_d = br_tgt;
                    end else if (op == OP_J) begin
                        pc_d = jmp_tgt;
                    end
                    state_d = FETCH;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    wdata_d = 32'd0;
                    addr_d  = (op == OP_BEQ && a_q == b_q) ? br_tgt :
                              (op == OP_J) ? jmp_tgt : pc_q;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    // a completed store hands straight over to the next fetch
                    if (we_q) begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = pc_q;
                        wdata_d = 32'd0;
                    end else begin
                        mdr_d   = mem_rdata;
                        req_d   = 1'b0;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rf_we   = 1'b1;
                state_d = FETCH;
                req_d   = 1'b1;
                we_d    = 1'b0;
                addr_d  = pc_q;
                wdata_d = 32'd0;
            end
            HALT: begin
                req_d  = 1'b0;
                we_d   = 1'b0;
                halt_d = 1'b1;
            end
            default: begin
                state_d = HALT;
                req_d   = 1'b0;
                halt_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            alu_q   <= 32'd0;
            mdr_q   <= 32'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            halt_q  <= halt_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (rf_we && rf_waddr != 5'd0) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign halt      = halt_q;
    assign pc_out    = pc_q;

endmodule

// File: tb/tb_m_cycle_cpu.sv
// Directed programs for m_cycle_cpu against a wait-state memory model.
// Every memory transaction is matched against an expected-transaction queue.
module tb_m_cycle_cpu;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, halt;
    logic [31:0] mem_addr, mem_wdata, pc_out;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        reset1;
    logic        mem_req1, mem_we1, halt1;
    logic [31:0] mem_addr1, mem_wdata1, pc_out1;
    logic [31:0] mem_rdata1;
    logic        mem_ready1;

    m_cycle_cpu #(.RESET_PC(32'h0), .HALT_ON_ILLEGAL(1'b1)) u0 (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .halt(halt), .pc_out(pc_out)
    );

    m_cycle_cpu #(.RESET_PC(32'h0), .HALT_ON_ILLEGAL(1'b0)) u1 (
        .clock(clock), .reset(reset1),
        .mem_req(mem_req1), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .mem_ready(mem_ready1),
        .halt(halt1), .pc_out(pc_out1)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          we;
        bit          fetch;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        sbq[$];
    int          fst[$];
    logic [31:0] mem [0:255];
    int          n_vec = 0;
    int          n_err = 0;
    int          cycle_n = 0;
    int          wait_n = 0;
    bit          stall_st = 1'b0;
    bit          pend = 1'b0;
    int          waited;
    int          s_cyc;
    logic        s_we;
    logic [31:0] s_addr, s_wd;

    localparam logic [31:0] ILL = 32'hFC00_0000;

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] ej(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ef(input logic [31:0] a);
        txn_t t;
        t.we = 1'b0; t.fetch = 1'b1; t.addr = a; t.data = 32'd0;
        sbq.push_back(t);
    endtask

    task automatic el(input logic [31:0] a);
        txn_t t;
        t.we = 1'b0; t.fetch = 1'b0; t.addr = a; t.data = 32'd0;
        sbq.push_back(t);
    endtask

    task automatic es(input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.we = 1'b1; t.fetch = 1'b0; t.addr = a; t.data = d;
        sbq.push_back(t);
    endtask

    task automatic complete();
        txn_t e;
        chk("hold_we", 32'(mem_we), 32'(s_we));
        chk("hold_addr", mem_addr, s_addr);
        chk("hold_wdata", mem_wdata, s_wd);
        n_vec++;
        assert (sbq.size() != 0) else begin
            n_err++;
            $error("FAIL unexpected_txn: observed addr %h we %0d expected none", mem_addr, mem_we);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("txn_we", 32'(mem_we), 32'(e.we));
            chk("txn_addr", mem_addr, e.addr);
            if (e.we) chk("txn_wdata", mem_wdata, e.data);
            if (e.fetch) fst.push_back(s_cyc);
        end
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
        else mem_rdata = mem[mem_addr[9:2]];
    endtask

    task automatic cyc();
        @(negedge clock);
        cycle_n++;
        mem_ready = 1'b0;
        if (mem_req) begin
            if (!pend) begin
                pend = 1'b1; waited = 0; s_cyc = cycle_n;
                s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata;
            end
            if (waited >= wait_n && !(stall_st && s_we)) begin
                mem_ready = 1'b1;
                complete();
                pend = 1'b0;
            end else begin
                waited++;
            end
        end else begin
            // ready while idle must be ignored by the core
            mem_ready = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b0;
        pend = 1'b0;
        sbq.delete();
        fst.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, 32'h0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    task automatic run_halt(input string tag, input int max, input logic [31:0] pc_exp);
        for (int i = 0; i < max; i++) begin
            if (halt) break;
            cyc();
        end
        chk({tag, "_halt"}, 32'(halt), 32'd1);
        chk({tag, "_pc"}, pc_out, pc_exp);
        repeat (10) cyc();
        chk({tag, "_stay_halt"}, 32'(halt), 32'd1);
        chk({tag, "_no_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_drained"}, 32'(sbq.size()), 32'd0);
    endtask

    task automatic chk_cyc(input string tag, input int a, input int n);
        chk(tag, 32'(fst[a + 1] - fst[a]), 32'(n));
    endtask

    initial begin
        reset = 1'b0;
        reset1 = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        mem_ready1 = 1'b1;
        mem_rdata1 = ILL;
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_pc", pc_out, 32'h0);

        // Program A: ALU ops, store/load, zero-wait timing
        clear_mem();
        mem[0] = ei(6'h0D, 5'd0, 5'd1, 16'd5);
        mem[1] = ei(6'h0D, 5'd0, 5'd2, 16'd3);
        mem[2] = er(5'd1, 5'd2, 5'd3, 6'h23);
        mem[3] = er(5'd2, 5'd1, 5'd4, 6'h2A);
        mem[4] = ei(6'h2B, 5'd0, 5'd3, 16'h80);
        mem[5] = ei(6'h2B, 5'd0, 5'd4, 16'h84);
        mem[6] = ei(6'h2B, 5'd0, 5'd1, 16'h8);
        mem[7] = ei(6'h23, 5'd0, 5'd5, 16'h8);
        mem[8] = ei(6'h2B, 5'd0, 5'd5, 16'h88);
        mem[9] = ILL;
        wait_n = 0;
        do_reset();
        ef(32'h00); ef(32'h04); ef(32'h08); ef(32'h0C);
        ef(32'h10); es(32'h80, 32'd2);
        ef(32'h14); es(32'h84, 32'd1);
        ef(32'h18); es(32'h08, 32'd5);
        ef(32'h1C); el(32'h08);
        ef(32'h20); es(32'h88, 32'd5);
        ef(32'h24);
        run_halt("A", 300, 32'h28);
        chk_cyc("A_ori1_cyc", 0, 4);
        chk_cyc("A_ori2_cyc", 1, 4);
        chk_cyc("A_subu_cyc", 2, 4);
        chk_cyc("A_slt_cyc", 3, 4);
        chk_cyc("A_sw_cyc", 4, 4);
        chk_cyc("A_lw_cyc", 7, 5);

        // Program B: 3 wait states per request
        clear_mem();
        mem[0]  = ei(6'h0D, 5'd0, 5'd1, 16'd5);
        mem[1]  = ej(26'h8);
        mem[8]  = ei(6'h2B, 5'd0, 5'd1, 16'h8);
        mem[9]  = ei(6'h23, 5'd0, 5'd5, 16'h8);
        mem[10] = ei(6'h2B, 5'd0, 5'd5, 16'h88);
        mem[11] = ILL;
        wait_n = 3;
        do_reset();
        ef(32'h00); ef(32'h04);
        ef(32'h20); es(32'h08, 32'd5);
        ef(32'h24); el(32'h08);
        ef(32'h28); es(32'h88, 32'd5);
        ef(32'h2C);
        run_halt("B", 400, 32'h30);
        chk("B_mem8", mem[2], 32'd5);
        chk_cyc("B_sw_cyc", 2, 10);
        chk_cyc("B_lw_cyc", 3, 11);

        // Program C: branches, jump, $0, immediates, misaligned load
        clear_mem();
        mem[0]  = ei(6'h0D, 5'd0, 5'd1, 16'd1);
        mem[1]  = ei(6'h09, 5'd2, 5'd2, 16'd1);
        mem[2]  = ei(6'h2B, 5'd0, 5'd2, 16'h80);
        mem[3]  = ei(6'h0F, 5'd0, 5'd8, 16'h1234);
        mem[4]  = ei(6'h04, 5'd2, 5'd1, 16'hFFFC);
        mem[5]  = ej(26'h40);
        mem[64] = ei(6'h2B, 5'd0, 5'd8, 16'h84);
        mem[65] = ei(6'h09, 5'd0, 5'd0, 16'd7);
        mem[66] = ei(6'h2B, 5'd0, 5'd0, 16'h88);
        mem[67] = ei(6'h09, 5'd0, 5'd9, 16'hFFFD);
        mem[68] = ei(6'h2B, 5'd0, 5'd9, 16'h8C);
        mem[69] = ei(6'h0C, 5'd9, 5'd10, 16'hF0F0);
        mem[70] = ei(6'h2B, 5'd0, 5'd10, 16'h90);
        mem[71] = er(5'd9, 5'd1, 5'd11, 6'h2A);
        mem[72] = ei(6'h2B, 5'd0, 5'd11, 16'h94);
        mem[73] = er(5'd9, 5'd8, 5'd13, 6'h21);
        mem[74] = er(5'd1, 5'd10, 5'd14, 6'h25);
        mem[75] = er(5'd10, 5'd9, 5'd15, 6'h24);
        mem[76] = ei(6'h2B, 5'd0, 5'd13, 16'h98);
        mem[77] = ei(6'h2B, 5'd0, 5'd14, 16'h9C);
        mem[78] = ei(6'h2B, 5'd0, 5'd15, 16'hA0);
        mem[79] = ei(6'h23, 5'd0, 5'd12, 16'h6);
        wait_n = 0;
        do_reset();
        ef(32'h00); ef(32'h04); ef(32'h08); es(32'h80, 32'd1);
        ef(32'h0C); ef(32'h10);
        ef(32'h04); ef(32'h08); es(32'h80, 32'd2);
        ef(32'h0C); ef(32'h10); ef(32'h14);
        ef(32'h100); es(32'h84, 32'h1234_0000);
        ef(32'h104); ef(32'h108); es(32'h88, 32'd0);
        ef(32'h10C); ef(32'h110); es(32'h8C, 32'hFFFF_FFFD);
        ef(32'h114); ef(32'h118); es(32'h90, 32'h0000_F0F0);
        ef(32'h11C); ef(32'h120); es(32'h94, 32'd1);
        ef(32'h124); ef(32'h128); ef(32'h12C);
        ef(32'h130); es(32'h98, 32'h1233_FFFD);
        ef(32'h134); es(32'h9C, 32'h0000_F0F1);
        ef(32'h138); es(32'hA0, 32'h0000_F0F0);
        ef(32'h13C);
        run_halt("C", 600, 32'h140);
        chk_cyc("C_beq_taken_cyc", 4, 3);
        chk_cyc("C_beq_not_cyc", 8, 3);
        chk_cyc("C_j_cyc", 9, 3);

        // Program D: reset pulsed while a store is stalled
        clear_mem();
        mem[0]  = ei(6'h0D, 5'd0, 5'd1, 16'd9);
        mem[1]  = ei(6'h2B, 5'd0, 5'd1, 16'h80);
        mem[32] = 32'hDEAD_BEEF;
        wait_n = 0;
        stall_st = 1'b1;
        do_reset();
        ef(32'h00); ef(32'h04);
        for (int i = 0; i < 50; i++) begin
            if (pend && s_we) break;
            cyc();
        end
        repeat (3) cyc();
        chk("D_store_waiting", {31'd0, mem_req & mem_we}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("D_async_req", 32'(mem_req), 32'd0);
        chk("D_async_we", 32'(mem_we), 32'd0);
        chk("D_async_addr", mem_addr, 32'd0);
        chk("D_async_wdata", mem_wdata, 32'd0);
        chk("D_async_pc", pc_out, 32'h0);
        stall_st = 1'b0;
        mem[0] = ILL;
        do_reset();
        ef(32'h00);
        run_halt("D", 100, 32'h4);
        chk("D_no_store", mem[32], 32'hDEAD_BEEF);

        // Second core: illegal opcode retires as a NOP
        @(negedge clock);
        reset1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (mem_req1 && mem_addr1 != 32'd0) break;
        end
        chk("nop_next_addr", mem_addr1, 32'h4);
        chk("nop_req", 32'(mem_req1), 32'd1);
        chk("nop_halt", 32'(halt1), 32'd0);
        chk("nop_pc", pc_out1, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/m_cycle_cpu.md
M_CYCLE_CPU -- requirements
Module: m_cycle_cpu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter HALT_ON_ILLEGAL, default 1; 1 = undefined instruction halts the core, 0 = undefined instruction retires as a NOP.
REQ-003 Port clock, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset.
REQ-005 Port mem_req, output, 1, memory request valid.
REQ-006 Port mem_we, output, 1, 1 = store, 0 = load/fetch; meaningful only while mem_req=1.
REQ-007 Port mem_addr, output, 32, byte address, always word-aligned when mem_req=1.
REQ-008 Port mem_wdata, output, 32, store data.
REQ-009 Port mem_rdata, input, 32, read data; valid in the cycle where mem_ready=1.
REQ-010 Port mem_ready, input, 1, memory completes the pending request at this edge.
REQ-011 Port halt, output, 1, core stopped.
REQ-012 Port pc_out, output, 32, current architectural PC, for debug.

Function
REQ-013 Instruction set: addu, subu, and, or, slt (R-type); addiu, andi, ori, lui; lw, sw; beq; j.
REQ-014 Sign extension applies to addiu/lw/sw/beq. Zero extension applies to andi/ori. lui places imm in bits [31:16].
REQ-015 FSM states are FETCH, DECODE, EXEC, MEM, WB and HALT. All outputs are registered, or decoded from state registers only.
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=PC. On the edge with mem_ready=1: latch IR <= mem_rdata, PC <= PC+4, go to DECODE.
REQ-017 DECODE: read rs/rt into A/B; go to EXEC. Undefined opcode/funct goes to HALT if HALT_ON_ILLEGAL=1, otherwise to FETCH.
REQ-018 EXEC, R/I ALU ops: compute result, go to WB.
REQ-019 EXEC, beq: if A==B, PC <= PC + (sext(imm)<<2); go to FETCH.
REQ-020 EXEC, j: PC <= {PC[31:28], IR[25:0], 2'b00}; go to FETCH.
REQ-021 EXEC, lw/sw: compute address; go to MEM, or to HALT if address[1:0]!=0, with no memory request issued.
REQ-022 MEM: mem_req=1, mem_addr=address. For sw: mem_we=1, mem_wdata=B, go to FETCH on mem_ready. For lw: mem_we=0, latch mem_rdata on mem_ready, go to WB.
REQ-023 WB: write rd (R-type) or rt (I-type, lw), then go to FETCH. Writes to register 0 are discarded; register 0 always reads 0.
REQ-024 Handshake: once mem_req=1, mem_req/mem_we/mem_addr/mem_wdata stay stable until the edge where mem_ready=1. mem_req=0 in the cycle following completion.
REQ-025 mem_ready while mem_req=0 is ignored. Unbounded wait states are tolerated with no timeout.
REQ-026 Cycle counts with zero-wait memory: ALU ops 4, lw 5, sw 4, beq 3, j 3.
REQ-027 Arithmetic is 32-bit modulo; addu/subu/addiu ignore overflow. slt is a signed compare.
REQ-028 HALT: mem_req=0 and halt=1; the core stays halted until reset. PC holds the address of the offending instruction + 4.
REQ-029 Simultaneous reset and mem_ready: reset wins; the transaction is abandoned.

Reset
REQ-030 On reset low, all of the following take effect immediately, without waiting for a clock edge:
- state=FETCH, PC=RESET_PC;
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
- halt=0, IR=0.
REQ-031 Register file contents are cleared to 0 on reset.
REQ-032 First rising edge after reset deasserts: mem_req=1, mem_addr=RESET_PC.
REQ-033 Reset asserted mid-transaction drops mem_req in the same cycle. No register or PC update from that instruction is retained.

Verification
REQ-034 Program `ori $1,$0,5; ori $2,$0,3; subu $3,$1,$2; slt $4,$2,$1`, zero-wait -> $3=2, $4=1, each instruction takes 4 cycles.
REQ-035 `sw $1,8($0); lw $5,8($0)`, with mem_ready delayed 3 cycles per request -> request held stable while waiting, memory word 8 = 5, $5=5, lw takes 11 cycles.
REQ-036 beq taken at PC 0x10 with imm=-4 -> next fetch address 0x04. Not-taken beq -> next fetch address 0x14. j target 0x40 -> next fetch address 0x100.
REQ-037 `addiu $0,$0,7` -> $0 still reads 0. lw from address 0x6 -> halt=1, no mem_req, PC=offending+4.
REQ-038 Opcode 6'h3F with HALT_ON_ILLEGAL=1 -> halt=1 and the core stays halted. Same opcode with HALT_ON_ILLEGAL=0 -> treated as a NOP, next fetch at PC+4.
REQ-039 Reset pulsed during a stalled MEM store -> mem_req=0 asynchronously. After release, fetch restarts at RESET_PC with no store committed.
